// File: rtl/sweep_pkg.sv
// Shared types and default sizing for the sweep sequencer.
package sweep_pkg;

    localparam int DEF_ADDR_W   = 7;
    localparam int DEF_MAX_LAST = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sweep_sequencer.sv
// Index sweep generator: emits 0..last over a valid/ready handshake, then pulses done.
// Optional SWEEP_SEQUENCER_ABORT_EN adds an abort input that cancels a running sweep.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_LAST = DEF_MAX_LAST
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_idx,
`ifdef SWEEP_SEQUENCER_ABORT_EN
    input  logic              abort,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] MAX_LAST_C = ADDR_W'(MAX_LAST);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              abort_w;
    logic              at_last;
    logic [ADDR_W-1:0] last_clamped;

`ifdef SWEEP_SEQUENCER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign last_clamped = (last_idx > MAX_LAST_C) ? MAX_LAST_C : last_idx;
    assign at_last      = (idx_q == last_q);

    // Outputs come from registered state only, so out_valid never sees out_ready.
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign out_last  = (state_q == RUN) && at_last;
    assign done      = (state_q == DONE);
    assign out_idx   = idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    last_d  = last_clamped;
                end
            end
            RUN: begin
                // Abort wins over a transfer in the same cycle; the index stays put.
                if (abort_w) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (at_last) state_d = DONE;
                    else         idx_d   = idx_q + ADDR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed + randomized bench for sweep_sequencer against an index-count reference model.
module tb_sweep_sequencer;

    localparam int ADDR_W   = 7;
    localparam int MAX_LAST = 127;

    logic              clock = 1'b0;
    logic              resetN;
    logic              start;
    logic [ADDR_W-1:0] last_idx;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef SWEEP_SEQUENCER_ABORT_EN
    logic              abort;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    sweep_sequencer #(.ADDR_W(ADDR_W), .MAX_LAST(MAX_LAST)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .start     (start),
        .last_idx  (last_idx),
`ifdef SWEEP_SEQUENCER_ABORT_EN
        .abort     (abort),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag, input int exp_idx);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"},  out_last,  0);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_done"},  done,      0);
        check({tag, "_idx"},   out_idx,   exp_idx);
    endtask

    // Model: a sweep is the list 0..min(last,MAX_LAST); each ready cycle consumes one entry,
    // followed by one done cycle and a return to idle. Called at a negedge with the DUT idle.
    // mode: 0 = ready always, 1 = ready 1,0,1,0..., 2 = random ready.
    task automatic run_sweep(input int last, input int mode, input bit hold);
        int L, k, cyc;
        bit fin, rdy;
        L   = (last > MAX_LAST) ? MAX_LAST : last;
        k   = 0;
        cyc = 0;
        fin = 0;
        start    = 1'b1;
        last_idx = ADDR_W'(last);
        while (!fin) begin
            @(negedge clock);
            if (cyc >= 2000) begin
                n_assert++;
                n_fail++;
                $error("FAIL sweep_timeout: observed %0d cycles expected completion", cyc);
                return;
            end
            check("run_valid", out_valid, 1);
            check("run_idx",   out_idx,   k);
            check("run_last",  out_last,  (k == L));
            check("run_busy",  busy,      1);
            check("run_done",  done,      0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            // start/last_idx noise during the sweep must be ignored
            start    = hold ? 1'b1 : 1'($urandom_range(0, 1));
            last_idx = ADDR_W'($urandom);
            if (rdy) begin
                if (k == L) fin = 1;
                k++;
            end
            cyc++;
        end
        @(negedge clock);
        check("done_pulse", done,      1);
        check("done_valid", out_valid, 0);
        check("done_busy",  busy,      0);
        check("done_last",  out_last,  0);
        check("done_idx",   out_idx,   L);
        out_ready = 1'($urandom_range(0, 1));
        start     = 1'b1;   // start in the done cycle must not be queued
        @(negedge clock);
        check_quiet("post_done", L);
        if (!hold) begin
            start = 1'b0;
            @(negedge clock);
            check_quiet("idle_hold", L);
        end
    endtask

    initial begin
        resetN    = 1'b0;
        start     = 1'b0;
        last_idx  = '0;
        out_ready = 1'b0;
`ifdef SWEEP_SEQUENCER_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(negedge clock);
        check_quiet("reset", 0);
        resetN = 1'b1;
        @(negedge clock);
        check_quiet("idle_after_reset", 0);

        // Full-range sweep with constant ready
        run_sweep(127, 0, 0);
        // Toggling ready
        run_sweep(3, 1, 0);
        // Single-entry sweep
        run_sweep(0, 0, 0);

        // Reset in the middle of a sweep
        start     = 1'b1;
        last_idx  = 7'd127;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (50) @(negedge clock);
        check("mid_idx", out_idx, 50);
        #2 resetN = 1'b0;
        #1 check_quiet("async_reset", 0);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        check_quiet("after_reset_release", 0);
        @(negedge clock);
        check_quiet("no_done_after_reset", 0);
        run_sweep(5, 0, 0);

        // start held high across back-to-back sweeps
        run_sweep(2, 0, 1);
        run_sweep(2, 0, 0);

        // Randomized sweeps
        for (int i = 0; i < 6; i++)
            run_sweep(int'($urandom_range(0, 127)), 2, 0);

`ifdef SWEEP_SEQUENCER_ABORT_EN
        start     = 1'b1;
        last_idx  = 7'd127;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        check("abort_pre_idx", out_idx, 10);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check_quiet("abort_next", 10);
        @(negedge clock);
        check_quiet("abort_no_done", 10);
        run_sweep(4, 2, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
